// File: rtl/mem_bus_ctrl_if.sv
// External byte-memory bus: strobe/ack handshake with latched address, data and write enable.
interface mem_bus_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DAT_W  = 8
);
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DAT_W-1:0]  o_mem_dat;
  logic              o_mem_we;
  logic              o_mem_stb;
  logic [DAT_W-1:0]  i_mem_dat;
  logic              i_mem_ack;

  modport master (
    output o_mem_addr, o_mem_dat, o_mem_we, o_mem_stb,
    input  i_mem_dat, i_mem_ack
  );

  modport slave (
    input  o_mem_addr, o_mem_dat, o_mem_we, o_mem_stb,
    output i_mem_dat, i_mem_ack
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Single-transaction byte bus master between the register file and external memory,
// with a per-transaction ack timeout so a hung bus cannot stall the sequencer.
module mem_bus_ctrl #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DAT_W   = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DAT_W-1:0]  i_wdat,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [DAT_W-1:0]  o_rdat,
  output logic              o_load,
  mem_bus_ctrl_if.master    mem
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Strobe, busy and pulses are all registered alongside the state transition.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_err          <= 1'b0;
      o_rdat         <= '0;
      o_load         <= 1'b0;
      mem.o_mem_addr <= '0;
      mem.o_mem_dat  <= '0;
      mem.o_mem_we   <= 1'b0;
      mem.o_mem_stb  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      o_load <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req) begin
            mem.o_mem_addr <= i_addr;
            mem.o_mem_dat  <= i_wdat;
            mem.o_mem_we   <= i_we;
            mem.o_mem_stb  <= 1'b1;
            cnt            <= '0;
            o_busy         <= 1'b1;
            state          <= BUS;
          end
        end
        BUS: begin
          // Ack takes priority over the timeout on the final strobe cycle.
          if (mem.i_mem_ack) begin
            if (!mem.o_mem_we) o_rdat <= mem.i_mem_dat;
            o_load        <= ~mem.o_mem_we;
            o_done        <= 1'b1;
            mem.o_mem_stb <= 1'b0;
            state         <= DONE;
          end else if (TO_EN && (cnt == CNT_LAST)) begin
            o_err         <= 1'b1;
            mem.o_mem_stb <= 1'b0;
            state         <= ERR;
          end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE, ERR: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_busy        <= 1'b0;
          mem.o_mem_stb <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
